// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared access-size, fault-code and state definitions for the memory stage
package mem_access_pkg;
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MF_NONE = 2'd0;
  localparam logic [1:0] MF_ALIGN = 2'd1;
  localparam logic [1:0] MF_TIMEOUT = 2'd2;
  typedef enum logic {MA_IDLE, MA_WAIT} ma_state_e;
  function automatic logic is_aligned(input logic [1:0] bytes, input logic [1:0] lo);
    return bytes == MEM_B ? 1'b1 : bytes == MEM_H ? ~lo[0] : bytes == MEM_W ? lo == 2'b00 : 1'b0;
  endfunction
endpackage

// File: rtl/mem_access_load_formatter.sv
// load_formatter: picks the addressed byte/half/word lane from read data and extends it
module load_formatter
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  bytes,
  input  logic        unsigned_flag,
  output logic [31:0] value
);
  logic [31:0] t;
  assign t = rdata >> {addr_lo, 3'b000};
  always_comb
    value = bytes == MEM_B ? {{24{~unsigned_flag & t[7]}}, t[7:0]} :
            bytes == MEM_H ? {{16{~unsigned_flag & t[15]}}, t[15:0]} : t;
endmodule

// File: rtl/mem_access.sv
// mem_access: memory pipeline stage issuing req/ack data-memory transactions and producing writeback
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] alu_result,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  bytes,
  input  logic        unsigned_flag,
  input  logic        mem_to_reg,
  input  logic [4:0]  rd,
  input  logic        reg_we,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        run_out,
  output logic [31:0] reg_wdata_out,
  output logic [4:0]  rd_out,
  output logic        reg_we_out,
  output logic        mem_fault,
  output logic [1:0]  mem_fault_code
);
  ma_state_e state, state_nx;
  logic [7:0] cnt;
  logic [4:0] l_rd;
  logic l_reg_we, l_m2r, l_uns;
  logic [1:0] l_bytes, l_lo;
  logic [31:0] l_alu, load_val;
  logic mem_op, aligned, start, tmo;
  load_formatter u_fmt (
    .rdata(dmem_rdata), .addr_lo(l_lo), .bytes(l_bytes), .unsigned_flag(l_uns), .value(load_val)
  );
  assign mem_op = we | re;
  assign aligned = is_aligned(bytes, alu_result[1:0]);
  assign start = state == MA_IDLE && run && mem_op && aligned;
  assign tmo = state == MA_WAIT && !dmem_ack && cnt == 8'(DMEM_TIMEOUT - 1);
  assign stall = start || state == MA_WAIT;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= MA_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == MA_IDLE ? (start ? MA_WAIT : MA_IDLE) : (dmem_ack || tmo ? MA_IDLE : MA_WAIT);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      {l_rd, l_reg_we, l_m2r, l_uns, l_bytes, l_lo, l_alu} <= '0;
      {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} <= '0;
      {run_out, reg_wdata_out, rd_out, reg_we_out, mem_fault, mem_fault_code} <= '0;
    end else begin
      run_out <= 1'b0;
      mem_fault <= 1'b0;
      mem_fault_code <= MF_NONE;
      if (state == MA_IDLE && run) begin
        if (!mem_op) begin
          run_out <= 1'b1;
          reg_wdata_out <= alu_result;
          rd_out <= rd;
          reg_we_out <= reg_we;
        end else if (!aligned) begin
          run_out <= 1'b1;
          reg_we_out <= 1'b0;
          mem_fault <= 1'b1;
          mem_fault_code <= MF_ALIGN;
        end else begin
          cnt <= '0;
          dmem_req <= 1'b1;
          dmem_we <= we;
          dmem_addr <= {alu_result[31:2], 2'b00};
          dmem_be <= bytes == MEM_B ? 4'b0001 << alu_result[1:0] :
                     bytes == MEM_H ? 4'b0011 << alu_result[1:0] : 4'hF;
          dmem_wdata <= bytes == MEM_B ? {4{wdata[7:0]}} : bytes == MEM_H ? {2{wdata[15:0]}} : wdata;
          {l_rd, l_reg_we, l_m2r, l_uns, l_bytes, l_lo, l_alu} <=
            {rd, reg_we, mem_to_reg, unsigned_flag, bytes, alu_result[1:0], alu_result};
        end
      end else if (state == MA_WAIT) begin
        if (dmem_ack) begin
          dmem_req <= 1'b0;
          run_out <= 1'b1;
          rd_out <= l_rd;
          reg_we_out <= l_reg_we;
          reg_wdata_out <= l_m2r ? load_val : l_alu;
        end else if (tmo) begin
          dmem_req <= 1'b0;
          run_out <= 1'b1;
          reg_we_out <= 1'b0;
          mem_fault <= 1'b1;
          mem_fault_code <= MF_TIMEOUT;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end
endmodule
